// File: rtl/mish_toggle_monitor_if.sv
// rtl/mish_toggle_monitor_if.sv - sample input and report handshake bundle for mish_toggle_monitor
interface mish_toggle_monitor_if #(
    parameter int WIDTH = 43,
    parameter int CNT_W = 16
);
    localparam int HD_W = $clog2(WIDTH + 1);

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             rpt_valid;
    logic             rpt_ready;
    logic [CNT_W-1:0] rpt_toggles;
    logic [HD_W-1:0]  rpt_max_hd;
    logic             rpt_sat;

    modport master (
        output in_valid, in_data, rpt_ready,
        input  rpt_valid, rpt_toggles, rpt_max_hd, rpt_sat
    );

    modport slave (
        input  in_valid, in_data, rpt_ready,
        output rpt_valid, rpt_toggles, rpt_max_hd, rpt_sat
    );
endinterface

// File: rtl/mish_toggle_monitor.sv
// rtl/mish_toggle_monitor.sv - Hamming-distance switching activity monitor with windowed reports
module mish_toggle_monitor #(
    parameter int WIDTH  = 43,
    parameter int WINDOW = 256,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    mish_toggle_monitor_if.slave  bus,
    output logic                  overrun,
    output logic                  busy
);
    localparam int HD_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] WIN_C   = CNT_W'(WINDOW);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nx;

    logic [WIDTH-1:0] in_q, prev;
    logic             in_v_q, in_run_q;
    logic [HD_W-1:0]  hd_q, max_q, hd_nx, max_nx;
    logic             hd_v_q;
    logic [CNT_W-1:0] acc, tcnt, acc_nx, tcnt_nx;
    logic [CNT_W:0]   acc_sum;
    logic             sat_acc, sat_nx, win_close;
    logic             rpt_valid, rpt_sat;
    logic [CNT_W-1:0] rpt_toggles;
    logic [HD_W-1:0]  rpt_max_hd;

    function automatic logic [HD_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [HD_W-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + HD_W'(v[i]);
        end
        return n;
    endfunction

    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = IDLE;
        end else if (state == IDLE && bus.in_valid) begin
            state_nx = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // The add is one bit wider than the accumulator so the carry flags the clamp.
    always_comb begin
        hd_nx     = popcount(in_q ^ prev);
        acc_sum   = {1'b0, acc} + {{(CNT_W + 1 - HD_W){1'b0}}, hd_q};
        acc_nx    = acc_sum[CNT_W] ? CNT_MAX : acc_sum[CNT_W-1:0];
        sat_nx    = sat_acc | acc_sum[CNT_W];
        max_nx    = (hd_q > max_q) ? hd_q : max_q;
        tcnt_nx   = tcnt + CNT_W'(1);
        win_close = hd_v_q && (tcnt_nx == WIN_C);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q        <= '0;
            in_v_q      <= 1'b0;
            in_run_q    <= 1'b0;
            prev        <= '0;
            hd_q        <= '0;
            hd_v_q      <= 1'b0;
            acc         <= '0;
            max_q       <= '0;
            sat_acc     <= 1'b0;
            tcnt        <= '0;
            rpt_valid   <= 1'b0;
            rpt_toggles <= '0;
            rpt_max_hd  <= '0;
            rpt_sat     <= 1'b0;
            overrun     <= 1'b0;
        end else if (clear) begin
            in_q        <= '0;
            in_v_q      <= 1'b0;
            in_run_q    <= 1'b0;
            prev        <= '0;
            hd_q        <= '0;
            hd_v_q      <= 1'b0;
            acc         <= '0;
            max_q       <= '0;
            sat_acc     <= 1'b0;
            tcnt        <= '0;
            rpt_valid   <= 1'b0;
            rpt_toggles <= '0;
            rpt_max_hd  <= '0;
            rpt_sat     <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            in_v_q   <= bus.in_valid;
            in_run_q <= (state == RUN);
            if (bus.in_valid) begin
                in_q <= bus.in_data;
            end

            // The priming sample only seeds prev; later ones also yield a distance.
            hd_v_q <= in_v_q && in_run_q;
            if (in_v_q) begin
                prev <= in_q;
                if (in_run_q) begin
                    hd_q <= hd_nx;
                end
            end

            if (rpt_valid && bus.rpt_ready) begin
                rpt_valid <= 1'b0;
            end

            if (hd_v_q) begin
                if (win_close) begin
                    acc     <= '0;
                    max_q   <= '0;
                    sat_acc <= 1'b0;
                    tcnt    <= '0;
                    // A report being taken this very edge frees the slot for the new one.
                    if (!rpt_valid || bus.rpt_ready) begin
                        rpt_valid   <= 1'b1;
                        rpt_toggles <= acc_nx;
                        rpt_max_hd  <= max_nx;
                        rpt_sat     <= sat_nx;
                    end else begin
                        overrun <= 1'b1;
                    end
                end else begin
                    acc     <= acc_nx;
                    max_q   <= max_nx;
                    sat_acc <= sat_nx;
                    tcnt    <= tcnt_nx;
                end
            end
        end
    end

    assign busy            = (state != IDLE);
    assign bus.rpt_valid   = rpt_valid;
    assign bus.rpt_toggles = rpt_toggles;
    assign bus.rpt_max_hd  = rpt_max_hd;
    assign bus.rpt_sat     = rpt_sat;
endmodule

// File: tb/tb_mish_toggle_monitor.sv
// tb/tb_mish_toggle_monitor.sv - scoreboard bench for mish_toggle_monitor (two parameter sets)
module tb_mish_toggle_monitor;
    localparam int W = 43;

    typedef struct {
        int tog;
        int mhd;
        int sat;
    } rpt_t;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         clear    = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data  = '0;
    logic         ready_a  = 1'b0;
    int           ready_mode = 1;
    logic         ovr_a, busy_a, ovr_b, busy_b;

    int   tests = 0;
    int   fails = 0;
    rpt_t q_a[$];
    rpt_t q_b[$];

    bit           have_prev;
    logic [W-1:0] m_prev;
    int           sum[2], mx[2], cnt[2];
    bit           held[2];
    int           h_tog[2], h_mhd[2], h_sat[2];
    int           last_tog[2], last_mhd[2], last_sat[2];

    always #5 clk = ~clk;

    mish_toggle_monitor_if #(.WIDTH(W), .CNT_W(16)) bus_a ();
    mish_toggle_monitor_if #(.WIDTH(W), .CNT_W(8))  bus_b ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_data   = in_data;
    assign bus_a.rpt_ready = ready_a;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.in_data   = in_data;
    assign bus_b.rpt_ready = 1'b1;

    mish_toggle_monitor #(.WIDTH(W), .WINDOW(256), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus_a.slave),
        .overrun(ovr_a), .busy(busy_a)
    );

    mish_toggle_monitor #(.WIDTH(W), .WINDOW(16), .CNT_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus_b.slave),
        .overrun(ovr_b), .busy(busy_b)
    );

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       ready_a = 1'b0;
            1:       ready_a = 1'b1;
            default: ready_a = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: actual %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: a window is WINDOW consecutive sample-pair distances; total clamps at cap.
    function automatic void model_win(input int id, input int win, input int cap, input int hd);
        rpt_t e;
        sum[id] += hd;
        if (hd > mx[id]) mx[id] = hd;
        cnt[id]++;
        if (cnt[id] == win) begin
            e.tog = (sum[id] > cap) ? cap : sum[id];
            e.mhd = mx[id];
            e.sat = (sum[id] > cap) ? 1 : 0;
            if (id == 0) q_a.push_back(e);
            else         q_b.push_back(e);
            sum[id] = 0;
            mx[id]  = 0;
            cnt[id] = 0;
        end
    endfunction

    function automatic void model_sample(input logic [W-1:0] x);
        int hd;
        if (!have_prev) begin
            have_prev = 1;
        end else begin
            hd = $countones(x ^ m_prev);
            model_win(0, 256, 65535, hd);
            model_win(1, 16, 255, hd);
        end
        m_prev = x;
    endfunction

    function automatic void model_flush();
        have_prev = 0;
        for (int i = 0; i < 2; i++) begin
            sum[i] = 0;
            mx[i]  = 0;
            cnt[i] = 0;
        end
        q_a.delete();
        q_b.delete();
    endfunction

    function automatic logic [W-1:0] pat(input int kind, input int i);
        logic [W-1:0] one;
        logic [63:0]  r;
        one = 1;
        r   = {$urandom(), $urandom()};
        case (kind)
            0:       return '0;
            1:       return (i % 2 == 1) ? {W{1'b1}} : '0;
            2:       return one << (i % W);
            default: return r[W-1:0];
        endcase
    endfunction

    task automatic mon(input int id, input logic v, input logic r,
                       input int tog, input int mhd, input int sat);
        rpt_t e;
        if (v && held[id]) begin
            check($sformatf("hold_tog_%0d", id), tog, h_tog[id]);
            check($sformatf("hold_mhd_%0d", id), mhd, h_mhd[id]);
            check($sformatf("hold_sat_%0d", id), sat, h_sat[id]);
        end
        if (v && r) begin
            if ((id == 0 && q_a.size() == 0) || (id == 1 && q_b.size() == 0)) begin
                tests++;
                fails++;
                $display("FAIL unexpected_report_%0d: actual toggles %0d expected no report", id, tog);
            end else begin
                e = (id == 0) ? q_a.pop_front() : q_b.pop_front();
                check($sformatf("rpt_toggles_%0d", id), tog, e.tog);
                check($sformatf("rpt_max_hd_%0d", id), mhd, e.mhd);
                check($sformatf("rpt_sat_%0d", id), sat, e.sat);
                last_tog[id] = tog;
                last_mhd[id] = mhd;
                last_sat[id] = sat;
            end
        end
        held[id]  = v && !r;
        h_tog[id] = tog;
        h_mhd[id] = mhd;
        h_sat[id] = sat;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            held[0] = 0;
            held[1] = 0;
        end else begin
            mon(0, bus_a.rpt_valid, bus_a.rpt_ready, int'(bus_a.rpt_toggles),
                int'(bus_a.rpt_max_hd), int'(bus_a.rpt_sat));
            mon(1, bus_b.rpt_valid, bus_b.rpt_ready, int'(bus_b.rpt_toggles),
                int'(bus_b.rpt_max_hd), int'(bus_b.rpt_sat));
        end
    end

    task automatic send(input logic [W-1:0] x);
        in_valid = 1'b1;
        in_data  = x;
        @(posedge clk);
        #1;
        model_sample(x);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic burst(input int kind, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            send(pat(kind, i));
            if (gaps && $urandom_range(0, 3) == 0) idle(1);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 3000; i++) begin
            if (q_a.size() == 0 && q_b.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("drain_a", q_a.size(), 0);
        check("drain_b", q_b.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid_a"}, int'(bus_a.rpt_valid), 0);
        check({tag, "_tog_a"}, int'(bus_a.rpt_toggles), 0);
        check({tag, "_mhd_a"}, int'(bus_a.rpt_max_hd), 0);
        check({tag, "_sat_a"}, int'(bus_a.rpt_sat), 0);
        check({tag, "_ovr_a"}, int'(ovr_a), 0);
        check({tag, "_busy_a"}, int'(busy_a), 0);
        check({tag, "_valid_b"}, int'(bus_b.rpt_valid), 0);
        check({tag, "_ovr_b"}, int'(ovr_b), 0);
        check({tag, "_busy_b"}, int'(busy_b), 0);
    endtask

    task automatic do_clear();
        in_valid = 1'b0;
        clear    = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        model_flush();
        check("clear_busy", int'(busy_a), 0);
        check("clear_ovr", int'(ovr_a), 0);
        check("clear_valid", int'(bus_a.rpt_valid), 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: actual timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_flush();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // all-zero window, with report latency
        send('0);
        check("busy_after_first", int'(busy_a), 1);
        burst(0, 255, 0);
        send('0);
        in_valid = 1'b0;
        check("lat_k0", int'(bus_a.rpt_valid), 0);
        @(posedge clk); #1;
        check("lat_k1", int'(bus_a.rpt_valid), 0);
        @(posedge clk); #1;
        check("lat_k2", int'(bus_a.rpt_valid), 1);
        drain();
        check("t1_tog", last_tog[0], 0);
        check("t1_mhd", last_mhd[0], 0);

        // alternating all-zeros / all-ones, both parameter sets
        do_clear();
        burst(1, 257, 0);
        idle(3);
        drain();
        check("t2_tog", last_tog[0], 11008);
        check("t2_mhd", last_mhd[0], 43);
        check("t2_sat", last_sat[0], 0);
        check("t2_small_tog", last_tog[1], 255);
        check("t2_small_sat", last_sat[1], 1);
        check("t2_small_mhd", last_mhd[1], 43);

        // walking one
        do_clear();
        burst(2, 257, 0);
        idle(3);
        drain();
        check("t3_tog", last_tog[0], 512);
        check("t3_mhd", last_mhd[0], 2);

        // consumer stalls across two windows
        do_clear();
        ready_mode = 0;
        burst(1, 513, 0);
        idle(4);
        check("t4_ovr", int'(ovr_a), 1);
        check("t4_valid", int'(bus_a.rpt_valid), 1);
        check("t4_held_tog", int'(bus_a.rpt_toggles), 11008);
        void'(q_a.pop_back());
        check("t4_q_depth", q_a.size(), 1);
        ready_mode = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ready_mode = 0;
        check("t4_valid_after", int'(bus_a.rpt_valid), 0);
        check("t4_ovr_sticky", int'(ovr_a), 1);
        drain();
        ready_mode = 1;
        do_clear();

        // random data, random gaps, random ready
        ready_mode = 2;
        burst(3, 1200, 1);
        idle(3);
        drain();
        ready_mode = 1;
        check("t5_ovr", int'(ovr_a), 0);

        // clear collides with a valid sample mid-window
        do_clear();
        burst(3, 101, 0);
        in_valid = 1'b1;
        in_data  = pat(3, 0);
        clear    = 1'b1;
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        model_flush();
        check("t6_busy", int'(busy_a), 0);
        burst(0, 257, 0);
        idle(3);
        drain();
        check("t6_tog", last_tog[0], 0);

        // asynchronous reset mid-window
        burst(3, 150, 0);
        in_valid = 1'b0;
        check("t7_busy_pre", int'(busy_a), 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("async");
        model_flush();
        @(posedge clk); #1;
        rst_n = 1'b1;
        burst(1, 257, 0);
        idle(3);
        drain();
        check("t7_tog", last_tog[0], 11008);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
